// File: rtl/fpa_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : fpa_sched_adder / fpa_scheduler
//  Purpose  : fpa_sched_adder is a combinational single-precision adder.
//             It truncates the result and reports {Cout, overflow, underflow,
//             exception}.
//             fpa_scheduler shares one adder among NUM_REQ requesters. It
//             accepts one operand pair per valid/ready handshake and holds
//             the operands on the adder for SETTLE_CYCLES cycles. It then
//             registers the sum and flags and returns them with the
//             requester index on a valid/ready response port.
//  Options  : FPA_SCHED_FIXED_PRIO_EN - when defined, the arbiter is fixed
//             priority (lowest index wins) and there is no last-grant
//             pointer. When undefined, the arbiter is round-robin.
//  Ports    : clk, rst_n (async, active-low)
//             req_valid[NUM_REQ] / req_ready[NUM_REQ] (combinational grant)
//             req_a, req_b       : 32 bits per requester, packed by index
//             rsp_valid / rsp_ready, rsp_id[ID_W], rsp_sum[32],
//             rsp_flags[4] = {Cout, overflow, underflow, exception}
//             busy               : high whenever the FSM is not idle
//  Revision : 1.0 - initial release
// ============================================================================

module fpa_sched_adder (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] sum,
    output logic        cout,
    output logic        overflow,
    output logic        underflow,
    output logic        exception
);
    logic [8:0]  w_exp_a;
    logic [8:0]  w_exp_b;
    logic [23:0] w_man_a;
    logic [23:0] w_man_b;
    logic        w_a_big;
    logic        w_sign_l;
    logic [8:0]  w_exp_l;
    logic [8:0]  w_exp_s;
    logic [23:0] w_man_l;
    logic [23:0] w_man_s;
    logic [8:0]  w_diff;
    logic [23:0] w_man_s_sh;
    logic [24:0] w_val;
    logic [23:0] w_man_n;
    logic [8:0]  w_exp_n;
    logic        w_a_inf;
    logic        w_b_inf;
    logic        w_a_nan;
    logic        w_b_nan;

    always_comb begin
        // Denormals use an effective exponent of 1 and have no hidden bit.
        w_exp_a = (a[30:23] == 8'd0) ? 9'd1 : {1'b0, a[30:23]};
        w_exp_b = (b[30:23] == 8'd0) ? 9'd1 : {1'b0, b[30:23]};
        w_man_a = {(a[30:23] != 8'd0), a[22:0]};
        w_man_b = {(b[30:23] != 8'd0), b[22:0]};

        // Order the operands by magnitude so the subtraction never goes negative.
        w_a_big  = ({w_exp_a, w_man_a} >= {w_exp_b, w_man_b});
        w_sign_l = w_a_big ? a[31]   : b[31];
        w_exp_l  = w_a_big ? w_exp_a : w_exp_b;
        w_exp_s  = w_a_big ? w_exp_b : w_exp_a;
        w_man_l  = w_a_big ? w_man_a : w_man_b;
        w_man_s  = w_a_big ? w_man_b : w_man_a;

        w_diff     = w_exp_l - w_exp_s;
        w_man_s_sh = (w_diff > 9'd24) ? 24'd0 : (w_man_s >> w_diff);

        if (a[31] == b[31]) begin
            w_val = {1'b0, w_man_l} + {1'b0, w_man_s_sh};
        end else begin
            w_val = {1'b0, w_man_l - w_man_s_sh};
        end

        // A carry out renormalises right by one. Otherwise shift left until
        // the hidden bit is set or the exponent reaches the denormal floor.
        w_exp_n = w_exp_l;
        if (w_val[24]) begin
            w_man_n = w_val[24:1];
            w_exp_n = w_exp_l + 9'd1;
        end else begin
            w_man_n = w_val[23:0];
            for (int i = 0; i < 23; i++) begin
                if (!w_man_n[23] && (w_exp_n > 9'd1)) begin
                    w_man_n = {w_man_n[22:0], 1'b0};
                    w_exp_n = w_exp_n - 9'd1;
                end
            end
        end

        w_a_inf = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
        w_b_inf = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
        w_a_nan = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
        w_b_nan = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);

        sum       = {w_sign_l, w_exp_n[7:0], w_man_n[22:0]};
        cout      = w_val[24];
        overflow  = 1'b0;
        underflow = 1'b0;
        exception = 1'b0;

        if (w_a_inf || w_b_inf || w_a_nan || w_b_nan) begin
            exception = 1'b1;
            cout      = 1'b0;
            if (w_a_nan || w_b_nan || (w_a_inf && w_b_inf && (a[31] != b[31]))) begin
                sum = 32'h7FC0_0000;
            end else if (w_a_inf) begin
                sum = {a[31], 8'hFF, 23'd0};
            end else begin
                sum = {b[31], 8'hFF, 23'd0};
            end
        end else if (w_exp_n >= 9'd255) begin
            overflow = 1'b1;
            sum      = {w_sign_l, 8'hFF, 23'd0};
        end else if (!w_man_n[23]) begin
            // Denormal or exact zero. An exact cancellation returns +0.
            underflow = (w_man_n != 24'd0);
            sum       = {(w_man_n != 24'd0) & w_sign_l, 8'd0, w_man_n[22:0]};
        end
    end
endmodule

module fpa_scheduler #(
    parameter int NUM_REQ       = 4,
    parameter int ID_W          = 2,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req_valid,
    output logic [NUM_REQ-1:0]   req_ready,
    input  logic [32*NUM_REQ-1:0] req_a,
    input  logic [32*NUM_REQ-1:0] req_b,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [ID_W-1:0]      rsp_id,
    output logic [31:0]          rsp_sum,
    output logic [3:0]           rsp_flags,
    output logic                 busy
);
    localparam int c_cnt_w = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [31:0]          r_op_a;
    logic [31:0]          r_op_b;
    logic [ID_W-1:0]      r_id;
    logic [c_cnt_w-1:0]   r_cnt;
    logic [ID_W-1:0]      r_rsp_id;
    logic [31:0]          r_rsp_sum;
    logic [3:0]           r_rsp_flags;

    logic [NUM_REQ-1:0]   w_grant;
    logic [ID_W-1:0]      w_grant_idx;
    logic                 w_grant_any;
    logic [31:0]          w_sel_a;
    logic [31:0]          w_sel_b;
    logic [31:0]          w_fpa_sum;
    logic                 w_fpa_cout;
    logic                 w_fpa_ovf;
    logic                 w_fpa_unf;
    logic                 w_fpa_exc;

    // ------------------------------------------------------------------
    // Arbiter
    // ------------------------------------------------------------------
`ifdef FPA_SCHED_FIXED_PRIO_EN
    always_comb begin
        w_grant     = '0;
        w_grant_idx = '0;
        w_grant_any = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_valid[i] && !w_grant_any) begin
                w_grant_any = 1'b1;
                w_grant_idx = ID_W'(i);
            end
        end
        if (w_grant_any) begin
            w_grant[w_grant_idx] = 1'b1;
        end
    end
`else
    logic [ID_W-1:0] r_last;
    logic [ID_W-1:0] w_hi_idx;
    logic [ID_W-1:0] w_lo_idx;
    logic            w_hi_any;
    logic            w_lo_any;

    // Round-robin as two priority searches. The first search covers indices
    // above the last grant. If it finds nothing, the lowest valid index wins,
    // which wraps the search.
    always_comb begin
        w_grant  = '0;
        w_hi_idx = '0;
        w_lo_idx = '0;
        w_hi_any = 1'b0;
        w_lo_any = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_valid[i] && (i > int'(r_last)) && !w_hi_any) begin
                w_hi_any = 1'b1;
                w_hi_idx = ID_W'(i);
            end
            if (req_valid[i] && !w_lo_any) begin
                w_lo_any = 1'b1;
                w_lo_idx = ID_W'(i);
            end
        end
        w_grant_any = w_hi_any | w_lo_any;
        w_grant_idx = w_hi_any ? w_hi_idx : w_lo_idx;
        if (w_grant_any) begin
            w_grant[w_grant_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last <= ID_W'(NUM_REQ - 1);
        end else if ((r_state == S_IDLE) && w_grant_any) begin
            r_last <= w_grant_idx;
        end
    end
`endif

    always_comb begin
        w_sel_a = 32'd0;
        w_sel_b = 32'd0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_grant[i]) begin
                w_sel_a = req_a[32*i +: 32];
                w_sel_b = req_b[32*i +: 32];
            end
        end
    end

    // ------------------------------------------------------------------
    // Shared adder. It is fed only from the operand registers.
    // ------------------------------------------------------------------
    fpa_sched_adder u_fpa (
        .a         (r_op_a),
        .b         (r_op_b),
        .sum       (w_fpa_sum),
        .cout      (w_fpa_cout),
        .overflow  (w_fpa_ovf),
        .underflow (w_fpa_unf),
        .exception (w_fpa_exc)
    );

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_grant_any)         w_state_nxt = S_EXEC;
            S_EXEC:  if (r_cnt == '0)         w_state_nxt = S_RESP;
            S_RESP:  if (rsp_ready)           w_state_nxt = S_IDLE;
            default:                          w_state_nxt = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op_a      <= 32'd0;
            r_op_b      <= 32'd0;
            r_id        <= '0;
            r_cnt       <= '0;
            r_rsp_id    <= '0;
            r_rsp_sum   <= 32'd0;
            r_rsp_flags <= 4'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_grant_any) begin
                        r_op_a <= w_sel_a;
                        r_op_b <= w_sel_b;
                        r_id   <= w_grant_idx;
                        r_cnt  <= c_cnt_w'(SETTLE_CYCLES - 1);
                    end
                end
                S_EXEC: begin
                    if (r_cnt == '0) begin
                        r_rsp_id    <= r_id;
                        r_rsp_sum   <= w_fpa_sum;
                        r_rsp_flags <= {w_fpa_cout, w_fpa_ovf, w_fpa_unf, w_fpa_exc};
                    end else begin
                        r_cnt <= r_cnt - c_cnt_w'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign req_ready = (r_state == S_IDLE) ? w_grant : '0;
    assign rsp_valid = (r_state == S_RESP);
    assign busy      = (r_state != S_IDLE);
    assign rsp_id    = r_rsp_id;
    assign rsp_sum   = r_rsp_sum;
    assign rsp_flags = r_rsp_flags;

endmodule
`default_nettype wire

// File: tb/tb_fpa_scheduler.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_fpa_scheduler
//  Purpose  : Self-checking bench for fpa_scheduler. Operands are signed
//             integers encoded as floats, so the expected sum is the float
//             encoding of the integer sum. Grant order is predicted by a
//             cyclic search from the last grant.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fpa_scheduler;
    localparam int N = 4;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    req_valid = '0;
    logic [N-1:0]    req_ready;
    logic [32*N-1:0] req_a = '0;
    logic [32*N-1:0] req_b = '0;
    logic            rsp_valid;
    logic            rsp_ready = 1'b0;
    logic [1:0]      rsp_id;
    logic [31:0]     rsp_sum;
    logic [3:0]      rsp_flags;
    logic            busy;

    // Shared inputs for the two settle-sweep instances
    logic [N-1:0]    sw_valid = '0;
    logic [32*N-1:0] sw_a = '0;
    logic [32*N-1:0] sw_b = '0;
    logic [N-1:0]    s1_ready, s4_ready;
    logic            s1_rv, s4_rv, s1_busy, s4_busy;
    logic [1:0]      s1_id, s4_id;
    logic [31:0]     s1_sum, s4_sum;
    logic [3:0]      s1_fl, s4_fl;

    fpa_scheduler #(.NUM_REQ(N), .ID_W(2), .SETTLE_CYCLES(2)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_sum(rsp_sum), .rsp_flags(rsp_flags), .busy(busy));

    fpa_scheduler #(.NUM_REQ(N), .ID_W(2), .SETTLE_CYCLES(1)) dut_s1 (
        .clk(clk), .rst_n(rst_n), .req_valid(sw_valid), .req_ready(s1_ready),
        .req_a(sw_a), .req_b(sw_b), .rsp_valid(s1_rv), .rsp_ready(1'b1),
        .rsp_id(s1_id), .rsp_sum(s1_sum), .rsp_flags(s1_fl), .busy(s1_busy));

    fpa_scheduler #(.NUM_REQ(N), .ID_W(2), .SETTLE_CYCLES(4)) dut_s4 (
        .clk(clk), .rst_n(rst_n), .req_valid(sw_valid), .req_ready(s4_ready),
        .req_a(sw_a), .req_b(sw_b), .rsp_valid(s4_rv), .rsp_ready(1'b1),
        .rsp_id(s4_id), .rsp_sum(s4_sum), .rsp_flags(s4_fl), .busy(s4_busy));

    always #5 clk = ~clk;

    typedef struct {
        int          id;
        logic [31:0] sum;
        logic [3:0]  fl;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   n_total = 0;
    int   n_bad = 0;
    int   m_last = N - 1;
    int   op_a[N];
    int   op_b[N];
    int   gr[5], rr_id[5];
    logic [31:0] rr_sum[5];
    int   ng, nr, w, cnt_rsp, cnt_gnt, bad_id, first1, first4, pick, drop, ea, eb;
    logic [31:0] exp_rdy, sum1, sum4;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_total++;
        if (obs !== expv) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, expv, $time);
        end
    endtask

    function automatic int msb_of(input int unsigned m);
        int p = -1;
        for (int i = 0; i < 32; i++) if (m[i]) p = i;
        return p;
    endfunction

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    // Float encoding of an integer with magnitude below 2^24
    function automatic logic [31:0] to_fp(input int v);
        int unsigned mag;
        int p;
        logic [31:0] f;
        if (v == 0) return 32'd0;
        mag = iabs(v);
        p = msb_of(mag);
        f[31]    = (v < 0);
        f[30:23] = 8'(127 + p);
        f[22:0]  = 23'((mag << (23 - p)) & 32'h007F_FFFF);
        return f;
    endfunction

    // A carry is expected only when two like-signed nonzero values add
    // to a magnitude with more integer bits than either operand.
    function automatic logic [3:0] exp_flags(input int a, input int b);
        int mx;
        if (a == 0 || b == 0 || ((a < 0) != (b < 0))) return 4'b0000;
        mx = (msb_of(iabs(a)) > msb_of(iabs(b))) ? msb_of(iabs(a)) : msb_of(iabs(b));
        return (msb_of(iabs(a + b)) > mx) ? 4'b1000 : 4'b0000;
    endfunction

    function automatic int rr_pick(input logic [N-1:0] v, input int last);
`ifdef FPA_SCHED_FIXED_PRIO_EN
        for (int i = 0; i < N; i++) if (v[i]) return i + 0 * last;
`else
        for (int k = 1; k <= N; k++) if (v[(last + k) % N]) return (last + k) % N;
`endif
        return -1;
    endfunction

    function automatic int onehot_idx(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return -1;
    endfunction

    task automatic set_req(input int i, input int a, input int b);
        req_valid[i]       = 1'b1;
        req_a[32*i +: 32]  = to_fp(a);
        req_b[32*i +: 32]  = to_fp(b);
        op_a[i] = a;
        op_b[i] = b;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req_valid = '0;
        sw_valid = '0;
        rsp_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        m_last = N - 1;
        q.delete();
    endtask

    function automatic int rnd_int();
        if ($urandom_range(0, 7) == 0) return 0;
        return int'($urandom_range(0, 2 * (1 << 20))) - (1 << 20);
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // ---------------- reset values ----------------
        @(negedge clk); #1;
        chk("rst_req_ready", req_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_id", rsp_id, 0);
        chk("rst_rsp_sum", rsp_sum, 0);
        chk("rst_rsp_flags", rsp_flags, 0);
        chk("rst_busy", busy, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // ---------------- single op: requester 2, 1.0 + 2.0 ----------------
        @(negedge clk);
        set_req(2, 1, 2);
        rsp_ready = 1'b1;
        #1 chk("single_ready", req_ready, 32'h4);
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            if (c == 1) req_valid[2] = 1'b0;
            #1;
            chk("single_busy", busy, (c <= 3) ? 1 : 0);
            chk("single_valid", rsp_valid, (c == 3) ? 1 : 0);
            if (c == 3) begin
                chk("single_id", rsp_id, 2);
                chk("single_sum", rsp_sum, 32'h4040_0000);
                chk("single_flags", rsp_flags, 0);
            end
        end

        // ---------------- settle sweep: 1.0 + 1.0 on SETTLE 1 and 4 ----------------
        @(negedge clk);
        sw_valid[0] = 1'b1;
        sw_a[31:0] = 32'h3F80_0000;
        sw_b[31:0] = 32'h3F80_0000;
        first1 = -1;
        first4 = -1;
        sum1 = 0;
        sum4 = 0;
        #1 chk("sweep_ready1", s1_ready, 1);
        chk("sweep_ready4", s4_ready, 1);
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (c == 1) sw_valid = '0;
            #1;
            if (s1_rv && first1 < 0) begin first1 = c; sum1 = s1_sum; end
            if (s4_rv && first4 < 0) begin first4 = c; sum4 = s4_sum; end
        end
        chk("sweep_lat1", first1, 2);
        chk("sweep_lat4", first4, 5);
        chk("sweep_sum1", sum1, 32'h4000_0000);
        chk("sweep_sum4", sum4, 32'h4000_0000);

        // ---------------- fairness: all requesters valid continuously ----------------
        do_reset();
        rsp_ready = 1'b1;
        for (int i = 0; i < N; i++) set_req(i, i + 1, 3);
        for (int k = 0; k < 5; k++) begin gr[k] = -1; rr_id[k] = -1; rr_sum[k] = 0; end
        ng = 0;
        nr = 0;
        for (int c = 0; c < 80 && nr < 5; c++) begin
            #1;
            if (req_ready != 0 && ng < 5) begin gr[ng] = onehot_idx(req_ready); ng++; end
            if (rsp_valid && nr < 5) begin rr_id[nr] = rsp_id; rr_sum[nr] = rsp_sum; nr++; end
            @(negedge clk);
        end
        req_valid = '0;
        chk("fair_rsp_count", nr, 5);
        for (int k = 0; k < 5; k++) begin
            pick = rr_pick(4'b1111, m_last);
            m_last = pick;
            chk("fair_grant", gr[k], pick);
            chk("fair_rsp_id", rr_id[k], pick);
            chk("fair_rsp_sum", rr_sum[k], to_fp(pick + 4));
        end

        // ---------------- backpressure ----------------
        do_reset();
        @(negedge clk);
        set_req(1, 5, 7);
        #1 chk("bp_grant", req_ready, 32'h2);
        @(negedge clk);
        req_valid[1] = 1'b0;
        set_req(3, 1, 1);
        #1;
        w = 0;
        while (!rsp_valid && w < 10) begin @(negedge clk); #1; w++; end
        chk("bp_arrive", rsp_valid, 1);
        for (int c = 0; c < 10; c++) begin
            chk("bp_valid_hold", rsp_valid, 1);
            chk("bp_sum_hold", rsp_sum, to_fp(12));
            chk("bp_ready_zero", req_ready, 0);
            @(negedge clk); #1;
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        req_valid = '0;
        #1;
        chk("bp_idle_busy", busy, 0);
        chk("bp_idle_valid", rsp_valid, 0);

        // ---------------- reset mid-op ----------------
        @(negedge clk);
        set_req(2, 3, 4);
        #1 chk("rm_grant", req_ready, 32'h4);
        @(negedge clk);
        req_valid = '0;
        #1 chk("rm_exec_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("rm_busy", busy, 0);
        chk("rm_rsp_valid", rsp_valid, 0);
        chk("rm_req_ready", req_ready, 0);
        chk("rm_rsp_id", rsp_id, 0);
        chk("rm_rsp_sum", rsp_sum, 0);
        chk("rm_rsp_flags", rsp_flags, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        cnt_rsp = 0;
        for (int c = 0; c < 6; c++) begin @(negedge clk); #1; if (rsp_valid) cnt_rsp++; end
        chk("rm_no_rsp", cnt_rsp, 0);
        @(negedge clk);
        set_req(0, 2, 2);
        set_req(3, 9, 9);
        #1 chk("rm_first_grant", req_ready, 32'h1);
        @(negedge clk);
        req_valid = '0;
        #1;
        w = 0;
        while (!rsp_valid && w < 10) begin @(negedge clk); #1; w++; end
        chk("rm_after_id", rsp_id, 0);
        chk("rm_after_sum", rsp_sum, to_fp(4));
        @(negedge clk);

        // ---------------- request withdrawal during EXEC ----------------
        @(negedge clk);
        set_req(0, 6, 1);
        #1 chk("wd_grant", req_ready, 32'h1);
        @(negedge clk);
        req_valid[0] = 1'b0;
        set_req(1, 8, 8);
        #1 chk("wd_ready_pulse", req_ready, 0);
        @(negedge clk);
        req_valid[1] = 1'b0;
        #1 chk("wd_ready_drop", req_ready, 0);
        cnt_rsp = 0;
        cnt_gnt = 0;
        bad_id = 0;
        for (int c = 0; c < 10; c++) begin
            if (rsp_valid) begin
                cnt_rsp++;
                if (rsp_id != 0 || rsp_sum != to_fp(7)) bad_id++;
            end
            if (req_ready != 0) cnt_gnt++;
            @(negedge clk); #1;
        end
        chk("wd_rsp_count", cnt_rsp, 1);
        chk("wd_rsp_content", bad_id, 0);
        chk("wd_grants", cnt_gnt, 0);

        // ---------------- randomized traffic ----------------
        do_reset();
        drop = -1;
        for (int cyc = 0; cyc < 600; cyc++) begin
            @(negedge clk);
            if (drop >= 0) req_valid[drop] = 1'b0;
            drop = -1;
            for (int i = 0; i < N; i++) begin
                if (!req_valid[i] && $urandom_range(0, 3) == 0) begin
                    ea = rnd_int();
                    eb = rnd_int();
                    set_req(i, ea, eb);
                end
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
            #1;
            if (busy) begin
                chk("rnd_ready_busy", req_ready, 0);
            end else begin
                pick = rr_pick(req_valid, m_last);
                exp_rdy = (pick < 0) ? 32'd0 : (32'd1 << pick);
                chk("rnd_grant", req_ready, exp_rdy);
                if (pick >= 0) begin
                    e.id  = pick;
                    e.sum = to_fp(op_a[pick] + op_b[pick]);
                    e.fl  = exp_flags(op_a[pick], op_b[pick]);
                    q.push_back(e);
                    m_last = pick;
                    drop = pick;
                end
            end
            if (rsp_valid && rsp_ready) begin
                if (q.size() == 0) begin
                    chk("rnd_spurious_rsp", 1, 0);
                end else begin
                    e = q.pop_front();
                    chk("rnd_rsp_id", rsp_id, e.id);
                    chk("rnd_rsp_sum", rsp_sum, e.sum);
                    chk("rnd_rsp_flags", rsp_flags, e.fl);
                end
            end
        end
        // drain
        @(negedge clk);
        req_valid = '0;
        rsp_ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            #1;
            if (rsp_valid) begin
                if (q.size() == 0) begin
                    chk("drain_spurious_rsp", 1, 0);
                end else begin
                    e = q.pop_front();
                    chk("drain_rsp_id", rsp_id, e.id);
                    chk("drain_rsp_sum", rsp_sum, e.sum);
                    chk("drain_rsp_flags", rsp_flags, e.fl);
                end
            end
            @(negedge clk);
        end
        chk("drain_empty", q.size(), 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
